// File: rtl/regfile_scan_pkg.sv
// Register-file scanner FSM states and the register-file geometry shared with the top level.
package regfile_scan_pkg;

   localparam int REG_ADD_WIDTH  = 5;
   localparam int REG_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } scan_state_t;

endpackage

// File: rtl/regfile_scanner.sv
// Dumps x0..x(2**ADD_WIDTH-1) through one registered read port as {idx, value} over valid/ready.
// Latency: 3 cycles per entry minimum; an entry is held in SEND until out_ready, then done pulses after the last.
module regfile_scanner
   import regfile_scan_pkg::*;
#(
   parameter int ADD_WIDTH  = REG_ADD_WIDTH,
   parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADD_WIDTH-1:0]  rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADD_WIDTH-1:0]  out_idx,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADD_WIDTH-1:0] LAST_IDX = '1;

   scan_state_t          state;
   scan_state_t          state_next;
   logic [ADD_WIDTH-1:0] idx;
   logic                 handshake;
   logic                 last;

   assign handshake = out_valid && out_ready;
   assign last      = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = ISSUE;
         ISSUE:   state_next = CAPTURE;
         CAPTURE: state_next = SEND;
         SEND:    if (handshake) state_next = last ? IDLE : ISSUE;
         default: state_next = IDLE;
      endcase
      // Abort only matters once a scan is running; in IDLE a concurrent start wins.
      if (abort && (state != IDLE)) begin
         state_next = IDLE;
      end
   end

   // All outputs derive from registers, so out_ready never reaches an output combinationally.
   always_comb begin
      busy      = (state != IDLE);
      out_valid = (state == SEND);
      rd_addr   = idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         out_idx  <= '0;
         out_data <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) idx <= '0;
            end
            CAPTURE: begin
               out_idx  <= idx;
               // The register file does not drive a fresh value for x0, so force it here.
               out_data <= (idx == '0) ? '0 : rd_data;
            end
            SEND: begin
               if (handshake && !abort) begin
                  if (last) begin
                     done <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/regfile_scanner.md
# regfile_scanner

Debug read-out engine for the CPU register file. On a `start` pulse it walks every architectural register, x0 through x(2**ADD_WIDTH-1), using one register-file read port. It streams each `{index, value}` pair out over a valid/ready interface, then pulses `done`. It sits beside the register file in the top level and drives one read-address port (AD1 or AD2 through a debug mux) for the testbench, FPGA dump logic or single-step monitor.

## Interface
- `ADD_WIDTH`, default 5: register address width; the scan covers 2**ADD_WIDTH registers.
- `DATA_WIDTH`, default 32: register data width.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a scan; sampled only in IDLE.
- `abort`  in  1: cancel an active scan.
- `rd_addr`  out  ADD_WIDTH: register-file read address (registered).
- `rd_data`  in  DATA_WIDTH: register-file read data (registered read, 1-cycle latency).
- `out_valid`  out  1: `out_idx`/`out_data` hold a valid entry.
- `out_ready`  in  1: consumer accepts the entry this cycle.
- `out_idx`  out  ADD_WIDTH: register number of the current entry.
- `out_data`  out  DATA_WIDTH: register value.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse after the last entry is accepted.

## Operation
- States: IDLE, ISSUE, CAPTURE, SEND.
- IDLE, `start`=1 → ISSUE; `idx`←0, `rd_addr`←0, `busy`←1.
- ISSUE, one cycle: `rd_addr` is stable and the register file samples it at the closing edge → CAPTURE.
- CAPTURE, one cycle: `rd_data` is valid.
  - At the closing edge, `out_data`←`rd_data`, `out_idx`←`idx`, `out_valid`←1 → SEND.
  - If `idx`==0, `out_data`←0 regardless of `rd_data`. The register file holds its previous RD value for address 0, so the scanner forces x0 to zero itself.
- SEND: hold `out_valid`, `out_idx` and `out_data` stable until `out_valid && out_ready`. On that handshake:
  - `idx` < 2**ADD_WIDTH-1: `idx`←`idx`+1, `rd_addr`←`idx`+1, `out_valid`←0 → ISSUE.
  - `idx` == 2**ADD_WIDTH-1: `out_valid`←0, `busy`←0, `done`←1 for one cycle → IDLE.
- `idx` never wraps: the terminal compare happens before the increment.
- `start` while `busy`: ignored. `start` in the same cycle as the `done` pulse: accepted, because the state is already IDLE.
- `abort` in any non-IDLE state, next edge: IDLE, `out_valid`=0, `busy`=0, no `done`. An entry that is mid-handshake on that cycle still counts as transferred.
- `abort` and `start` together in IDLE: `start` wins.
- The scan is not atomic. A CPU write to register k lands in the dump only if it occurs before k's ISSUE edge.
- `rd_addr` changes only on entry to ISSUE.

## Timing
- Reset values: state IDLE; `rd_addr`=0, `out_valid`=0, `out_idx`=0, `out_data`=0, `busy`=0, `done`=0.
- `start` high in cycle 0:
  - `busy` and ISSUE from cycle 1.
  - CAPTURE in cycle 2.
  - `out_valid` high from cycle 3.
- Each entry takes at least 3 cycles (ISSUE, CAPTURE, SEND with `out_ready`=1). A full scan with `out_ready` tied high takes 96 cycles, with `done` high in cycle 97 (ADD_WIDTH=5).
- `out_valid` never falls without a handshake, except on `abort`/`rst`.
- No combinational path from `out_ready` to any output.

## Structure
- Package `regfile_scan_pkg` holds:
  - the state enum (`IDLE`, `ISSUE`, `CAPTURE`, `SEND`);
  - default `ADD_WIDTH`/`DATA_WIDTH` constants, shared with the register file and the top level.
- Single module, no sub-module; the FSM, index counter and output register are small.
- The top level owns the debug mux that selects `rd_addr` onto a register-file AD port while `busy`.

## Test plan
- Preload x1..x31 with 0x1000+k and x0's RD with stale 0xDEADBEEF; pulse `start`, `out_ready`=1 → 32 entries, idx 0..31 in order; x0 data is 0; entry k is 0x1000+k; `done` in cycle 97; `busy` low with `done`.
- Same preload, `out_ready` toggling 1-0-0-1 → identical stream; `out_*` stable while stalled; no duplicates or drops.
- `start` pulsed again at entry 5 while busy → ignored, stream unaffected; `start` in the `done` cycle → new scan, first `out_valid` 3 cycles later.
- `abort` during SEND of idx 10 with `out_ready`=0 → next cycle `out_valid`=0, `busy`=0, no `done`; a fresh `start` restarts at idx 0.
- `rst` asserted mid-CAPTURE of idx 20 → all outputs at reset values next cycle; `start` afterwards scans from 0.
- CPU writes x7←0xABCD during the idx 3 SEND → entry 7 reads 0xABCD; a write to x2 at the same time is not reflected (entry already issued).
